// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: round-robin issue of reservation-station slots onto one ALU.
// Single-cycle ops return a result tag on the next cycle. DIV ops hold the ALU
// for DIV_CYCLES cycles. The result tag is held stable until routing accepts it.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   slot_ready            per-slot issue request
//   slot_is_div           per-slot DIV opcode flag, used only for the granted slot
//   flush                 aborts any in-flight work and any pending result
//   grant/fire/fire_slot  combinational issue outputs (one-hot grant, strobe, index)
//   res_valid/res_slot    registered result tag toward operand routing
//   res_ready             routing accepts the result tag
//   busy                  DIV in flight or result pending
module alu_issue_scheduler #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned SLOT_W     = 3,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SLOTS-1:0] slot_ready,
  input  logic [NUM_SLOTS-1:0] slot_is_div,
  input  logic                 flush,
  output logic [NUM_SLOTS-1:0] grant,
  output logic                 fire,
  output logic [SLOT_W-1:0]    fire_slot,
  output logic                 res_valid,
  output logic [SLOT_W-1:0]    res_slot,
  input  logic                 res_ready,
  output logic                 busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_WAIT = 2'd1,
    S_DIV_DONE = 2'd2
  } state_t;

  // DIV_DONE is entered when one cycle remains before the result is visible.
  // With the minimum latency of 2 that is already the cycle after fire.
  localparam state_t DIV_ENTRY = (DIV_CYCLES <= 2) ? S_DIV_DONE : S_DIV_WAIT;

  state_t              r_state;
  logic [SLOT_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]    r_div_cnt;
  logic [SLOT_W-1:0]   r_div_slot;
  logic                r_res_valid;
  logic [SLOT_W-1:0]   r_res_slot;

  state_t              w_state_nxt;
  logic [SLOT_W-1:0]   w_rr_ptr_nxt;
  logic [CNT_W-1:0]    w_div_cnt_nxt;
  logic [SLOT_W-1:0]   w_div_slot_nxt;
  logic                w_res_valid_nxt;
  logic [SLOT_W-1:0]   w_res_slot_nxt;

  logic                w_out_free;
  logic                w_found;
  logic [SLOT_W-1:0]   w_gidx;
  logic [SLOT_W:0]     w_sum;
  logic                w_fire_div;

  assign res_valid  = r_res_valid;
  assign res_slot   = r_res_slot;
  assign busy       = (r_state != S_IDLE) || r_res_valid;
  assign w_out_free = !r_res_valid || res_ready;

  // Round-robin search: first ready slot at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (SLOT_W+1)'(k);
      if (w_sum >= (SLOT_W+1)'(NUM_SLOTS)) begin
        w_sum = w_sum - (SLOT_W+1)'(NUM_SLOTS);
      end
      if (!w_found && slot_ready[w_sum[SLOT_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[SLOT_W-1:0];
      end
    end
  end

  // Next-state, next-register values and combinational issue outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_div_cnt_nxt   = r_div_cnt;
    w_div_slot_nxt  = r_div_slot;
    w_res_valid_nxt = r_res_valid;
    w_res_slot_nxt  = r_res_slot;
    fire            = 1'b0;
    grant           = '0;
    fire_slot       = '0;
    w_fire_div      = 1'b0;

    fire = !rst && !flush && (r_state == S_IDLE) && w_out_free && w_found;
    if (fire) begin
      grant      = NUM_SLOTS'(1) << w_gidx;
      fire_slot  = w_gidx;
      w_fire_div = slot_is_div[w_gidx];
    end

    // An accepted result drops unless a new one replaces it below.
    if (r_res_valid && res_ready) begin
      w_res_valid_nxt = 1'b0;
    end

    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_div_cnt_nxt   = '0;
      w_res_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fire) begin
            w_rr_ptr_nxt = (w_gidx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : w_gidx + SLOT_W'(1);
            if (w_fire_div) begin
              w_state_nxt    = DIV_ENTRY;
              w_div_cnt_nxt  = CNT_W'(DIV_CYCLES - 1);
              w_div_slot_nxt = w_gidx;
            end else begin
              w_res_valid_nxt = 1'b1;
              w_res_slot_nxt  = w_gidx;
            end
          end
        end
        S_DIV_WAIT: begin
          w_div_cnt_nxt = r_div_cnt - CNT_W'(1);
          if (r_div_cnt <= CNT_W'(2)) begin
            w_state_nxt = S_DIV_DONE;
          end
        end
        S_DIV_DONE: begin
          if (w_out_free) begin
            w_res_valid_nxt = 1'b1;
            w_res_slot_nxt  = r_div_slot;
            w_div_cnt_nxt   = '0;
            w_state_nxt     = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_div_cnt   <= '0;
      r_div_slot  <= '0;
      r_res_valid <= 1'b0;
      r_res_slot  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_div_cnt   <= w_div_cnt_nxt;
      r_div_slot  <= w_div_slot_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_slot  <= w_res_slot_nxt;
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_alu_issue_scheduler;

  localparam int unsigned N    = 8;
  localparam int unsigned DIVC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] slot_ready;
  logic [N-1:0] slot_is_div;
  logic         flush;
  logic [N-1:0] grant;
  logic         fire;
  logic [2:0]   fire_slot;
  logic         res_valid;
  logic [2:0]   res_slot;
  logic         res_ready;
  logic         busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.NUM_SLOTS(N), .SLOT_W(3), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst(rst), .slot_ready(slot_ready), .slot_is_div(slot_is_div),
    .flush(flush), .grant(grant), .fire(fire), .fire_slot(fire_slot),
    .res_valid(res_valid), .res_slot(res_slot), .res_ready(res_ready), .busy(busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; slot_ready = '0; slot_is_div = '0; res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; slot_ready = 8'hFF; slot_is_div = '0; res_ready = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire_gated: got %b expected 0", fire); end
    n_tests++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant_gated: got %h expected 00", grant); end
    @(negedge clk);
    rst = 1'b0; slot_ready = '0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_tests++; if (fire !== 1'b0) begin n_fail++; $display("FAIL idle_fire[%0d]: got %b expected 0", i, fire); end
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL idle_res_valid[%0d]: got %b expected 0", i, res_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy[%0d]: got %b expected 0", i, busy); end
    end
  endtask

  task automatic test_round_robin();
    int unsigned exp_s;
    int unsigned prev_s;
    do_reset();
    prev_s = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); slot_ready = 8'h24; #1;
      exp_s = (i % 2 == 0) ? 2 : 5;
      n_tests++; if (fire !== 1'b1 || fire_slot !== 3'(exp_s)) begin n_fail++; $display("FAIL rr_fire[%0d]: got fire=%b slot=%0d expected fire=1 slot=%0d", i, fire, fire_slot, exp_s); end
      n_tests++; if (grant !== (8'h01 << exp_s)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %h expected %h", i, grant, 8'h01 << exp_s); end
      if (i > 0) begin
        n_tests++; if (res_valid !== 1'b1 || res_slot !== 3'(prev_s)) begin n_fail++; $display("FAIL rr_result[%0d]: got v=%b slot=%0d expected v=1 slot=%0d", i, res_valid, res_slot, prev_s); end
      end
      prev_s = exp_s;
    end
    @(negedge clk); slot_ready = '0; #1;
    n_tests++; if (res_valid !== 1'b1 || res_slot !== 3'd5 || fire !== 1'b0) begin n_fail++; $display("FAIL rr_last_result: got v=%b slot=%0d fire=%b expected v=1 slot=5 fire=0", res_valid, res_slot, fire); end
  endtask

  task automatic test_div();
    do_reset();
    @(negedge clk); slot_ready = 8'h48; slot_is_div = 8'h08; #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd3) begin n_fail++; $display("FAIL div_fire: got fire=%b slot=%0d expected fire=1 slot=3", fire, fire_slot); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); slot_ready = 8'h40; slot_is_div = '0; #1;
      n_tests++; if (fire !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL div_wait[t+%0d]: got fire=%b v=%b busy=%b expected 0 0 1", i, fire, res_valid, busy); end
    end
    @(negedge clk); #1;
    n_tests++; if (res_valid !== 1'b1 || res_slot !== 3'd3) begin n_fail++; $display("FAIL div_result: got v=%b slot=%0d expected v=1 slot=3", res_valid, res_slot); end
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd6) begin n_fail++; $display("FAIL div_next_fire: got fire=%b slot=%0d expected fire=1 slot=6", fire, fire_slot); end
    @(negedge clk); slot_ready = '0; #1;
    n_tests++; if (res_valid !== 1'b1 || res_slot !== 3'd6) begin n_fail++; $display("FAIL div_b2b_result: got v=%b slot=%0d expected v=1 slot=6", res_valid, res_slot); end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk); slot_ready = 8'h02; res_ready = 1'b1; #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd1) begin n_fail++; $display("FAIL stall_fire: got fire=%b slot=%0d expected fire=1 slot=1", fire, fire_slot); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); slot_ready = 8'h10; res_ready = 1'b0; #1;
      n_tests++; if (res_valid !== 1'b1 || res_slot !== 3'd1 || fire !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b slot=%0d fire=%b expected v=1 slot=1 fire=0", i, res_valid, res_slot, fire); end
    end
    @(negedge clk); res_ready = 1'b1; #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd4 || res_slot !== 3'd1) begin n_fail++; $display("FAIL stall_resume: got fire=%b slot=%0d res_slot=%0d expected fire=1 slot=4 res_slot=1", fire, fire_slot, res_slot); end
    @(negedge clk); slot_ready = '0; #1;
    n_tests++; if (res_valid !== 1'b1 || res_slot !== 3'd4) begin n_fail++; $display("FAIL stall_next: got v=%b slot=%0d expected v=1 slot=4", res_valid, res_slot); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); slot_ready = 8'h01; slot_is_div = 8'h01; #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd0) begin n_fail++; $display("FAIL flush_div_fire: got fire=%b slot=%0d expected fire=1 slot=0", fire, fire_slot); end
    @(negedge clk); slot_ready = '0; slot_is_div = '0; #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
    @(negedge clk); flush = 1'b1; #1;
    n_tests++; if (fire !== 1'b0) begin n_fail++; $display("FAIL flush_fire: got %b expected 0", fire); end
    @(negedge clk); flush = 1'b0; #1;
    n_tests++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy=%b v=%b expected 0 0", busy, res_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_result[%0d]: got %b expected 0", i, res_valid); end
    end
    @(negedge clk); slot_ready = 8'h03; #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd1) begin n_fail++; $display("FAIL flush_rr_kept: got fire=%b slot=%0d expected fire=1 slot=1", fire, fire_slot); end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    @(negedge clk); slot_ready = 8'h10; slot_is_div = 8'h10; #1;
    n_tests++; if (fire_slot !== 3'd4) begin n_fail++; $display("FAIL rstdiv_fire: got slot=%0d expected 4", fire_slot); end
    @(negedge clk); slot_ready = '0; slot_is_div = '0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstdiv_quiet[%0d]: got v=%b busy=%b expected 0 0", i, res_valid, busy); end
      @(negedge clk);
    end
    slot_ready = 8'h11; #1;
    n_tests++; if (fire_slot !== 3'd0) begin n_fail++; $display("FAIL rstdiv_rr_cleared: got slot=%0d expected 0", fire_slot); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk); slot_ready = 8'h40; #1;
    n_tests++; if (fire_slot !== 3'd6) begin n_fail++; $display("FAIL wrap_setup: got slot=%0d expected 6", fire_slot); end
    @(negedge clk); slot_ready = 8'h81; #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd7 || grant !== 8'h80) begin n_fail++; $display("FAIL wrap_slot7: got fire=%b slot=%0d grant=%h expected 1 7 80", fire, fire_slot, grant); end
    @(negedge clk); #1;
    n_tests++; if (fire !== 1'b1 || fire_slot !== 3'd0 || grant !== 8'h01) begin n_fail++; $display("FAIL wrap_slot0: got fire=%b slot=%0d grant=%h expected 1 0 01", fire, fire_slot, grant); end
  endtask

  // Model: a DIV fired in cycle c has its result visible in cycle c+DIVC at the
  // earliest; it is loaded at the first edge at or after c+DIVC-1 where the
  // output is free. A DIV in flight blocks all issue.
  task automatic test_random(input int unsigned n_cycles);
    int unsigned m_rr, m_rs, m_due, m_dslot, g;
    bit m_rv, m_div, found, out_free, exp_fire, n_rv;
    do_reset();
    m_rr = 0; m_rs = 0; m_rv = 0; m_div = 0; m_due = 0; m_dslot = 0;
    for (int unsigned c = 0; c < n_cycles; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      slot_ready  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      slot_is_div = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      res_ready   = ($urandom_range(0, 3) != 0);
      #1;
      out_free = !m_rv || res_ready;
      found = 0; g = 0;
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && slot_ready[(m_rr + k) % N]) begin found = 1; g = (m_rr + k) % N; end
      end
      exp_fire = !rst && !flush && !m_div && out_free && found;
      n_tests++; if (fire !== exp_fire) begin n_fail++; $display("FAIL rand_fire[%0d]: got %b expected %b", c, fire, exp_fire); end
      if (exp_fire) begin
        n_tests++; if (fire_slot !== 3'(g) || grant !== (8'h01 << g)) begin n_fail++; $display("FAIL rand_grant[%0d]: got slot=%0d grant=%h expected slot=%0d grant=%h", c, fire_slot, grant, g, 8'h01 << g); end
      end else begin
        n_tests++; if (fire_slot !== 3'd0 || grant !== 8'h00) begin n_fail++; $display("FAIL rand_nogrant[%0d]: got slot=%0d grant=%h expected 0 00", c, fire_slot, grant); end
      end
      n_tests++; if (res_valid !== m_rv) begin n_fail++; $display("FAIL rand_res_valid[%0d]: got %b expected %b", c, res_valid, m_rv); end
      if (m_rv) begin
        n_tests++; if (res_slot !== 3'(m_rs)) begin n_fail++; $display("FAIL rand_res_slot[%0d]: got %0d expected %0d", c, res_slot, m_rs); end
      end
      n_tests++; if (busy !== (m_div || m_rv)) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, m_div || m_rv); end
      if (rst) begin
        m_rr = 0; m_rs = 0; m_rv = 0; m_div = 0;
      end else begin
        n_rv = m_rv && !res_ready;
        if (flush) begin
          m_div = 0; n_rv = 0;
        end else if (exp_fire) begin
          m_rr = (g + 1) % N;
          if (slot_is_div[g]) begin m_div = 1; m_due = c + DIVC; m_dslot = g; end
          else begin n_rv = 1; m_rs = g; end
        end else if (m_div && (c + 1 >= m_due) && out_free) begin
          n_rv = 1; m_rs = m_dslot; m_div = 0;
        end
        m_rv = n_rv;
      end
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; slot_ready = '0; slot_is_div = '0; res_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_div();
    test_stall();
    test_flush();
    test_reset_mid_div();
    test_wrap();
    test_random(4000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 Parameter: NUM_SLOTS, 8, number of reservation-station slots competing for the ALU.
REQ-002 Parameter: SLOT_W, 3, slot index width; SHALL equal clog2(NUM_SLOTS).
REQ-003 Parameter: DIV_CYCLES, 4, cycles from DIV fire to result; legal range 2..15.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 slot_ready  in  NUM_SLOTS  slot i holds operands plus true predicate and requests issue.
REQ-007 slot_is_div  in  NUM_SLOTS  slot i opcode is OP_DIV (multi-cycle); sampled only with its grant.
REQ-008 flush  in  1  block flush/commit; aborts in-flight work.
REQ-009 grant  out  NUM_SLOTS  one-hot issue grant to the slot; zero when fire=0.
REQ-010 fire  out  1  ALU fire strobe.
REQ-011 fire_slot  out  SLOT_W  index of the granted slot; 0 when fire=0.
REQ-012 res_valid  out  1  result tag valid toward operand routing.
REQ-013 res_slot  out  SLOT_W  slot index owning the current result.
REQ-014 res_ready  in  1  routing accepts result; transfer when res_valid && res_ready.
REQ-015 busy  out  1  state != IDLE or res_valid=1.

Function
REQ-016 States: IDLE, DIV_WAIT, DIV_DONE; 2-bit encoding, sole machine in block.
REQ-017 out_free = !res_valid || res_ready (combinational).
REQ-018 Issue (combinational): fire=1 iff state=IDLE, flush=0, out_free=1, |slot_ready=1.
REQ-019 Arbitration: round-robin; search starts at rr_ptr, ascending with wrap; first ready slot wins.
REQ-020 On fire, rr_ptr <= granted+1, wrapping NUM_SLOTS-1 -> 0; otherwise rr_ptr unchanged.
REQ-021 Non-DIV fire: next cycle res_valid=1, res_slot=granted index (1-cycle ALU latency); state stays IDLE.
REQ-022 DIV fire: state -> DIV_WAIT, div_cnt <= DIV_CYCLES-1, div_slot <= granted index; no result next cycle.
REQ-023 DIV_WAIT: div_cnt decrements each cycle; at div_cnt=1 -> DIV_DONE; no fire.
REQ-024 DIV_DONE: if out_free, res_valid<=1, res_slot<=div_slot, -> IDLE; else hold DIV_DONE.
REQ-025 DIV result therefore appears exactly DIV_CYCLES cycles after fire when routing is not stalled.
REQ-026 res_valid/res_slot SHALL hold stable while res_valid=1 and res_ready=0.
REQ-027 Accept without new result: res_valid<=0; accept with simultaneous new result: res_valid stays 1, res_slot updates (back-to-back, full throughput for non-DIV).
REQ-028 slot_ready deassertion after grant is the slot's duty; scheduler does not mask granted slots.
REQ-029 flush (highest priority): fire=0 that cycle; next cycle res_valid=0, state=IDLE, div_cnt=0; rr_ptr kept.
REQ-030 flush coincident with res_ready: transfer is considered accepted; no residual result.

Reset
REQ-031 While rst=1 at clk edge: state=IDLE, rr_ptr=0, div_cnt=0, div_slot=0, res_valid=0, res_slot=0.
REQ-032 Combinational outputs during reset cycle: fire, grant, fire_slot follow REQ-018 (zero when held in reset with rst dominating, i.e. fire gated by rst).
REQ-033 Reset mid-DIV discards the DIV; no result emitted afterward.

Verification
REQ-034 Reset, slot_ready=0x00 -> fire=0, res_valid=0, busy=0 for 10 cycles.
REQ-035 slot_ready=0x24 constant, res_ready=1, no DIV -> grants slot 2, 5, 2, 5 on consecutive cycles; res_slot 2, 5, ... one cycle later.
REQ-036 Slot 3 DIV (DIV_CYCLES=4) fired cycle t, slot 6 ready -> res_valid at t+4 slot 3; no fire t+1..t+3; slot 6 fires t+4.
REQ-037 Non-DIV result slot 1 with res_ready=0 for 3 cycles -> res_valid, res_slot=1 held; no fire; fire resumes cycle res_ready=1.
REQ-038 flush at t+2 during DIV of slot 0 -> state IDLE t+3, res_valid never asserts for slot 0, rr_ptr=1.
REQ-039 rr_ptr=7 with slot_ready=0x81 -> slot 7 granted, then slot 0 (wrap).
